alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator-side sequencer for the ALU's ACT/RDY/VLD handshake.
- Accepts one instruction at a time from an upstream valid/ready port and holds its operands.
- Issues the instruction to the ALU, collects the result (one beat for normal ops, two beats for MUL), and presents a 64-bit result plus tag on a downstream valid/ready port.
- Sits between the decode/operand-fetch stage and writeback.

Parameters:
- TAG_W, 4, width of the instruction tag carried from input to output.
- TIMEOUT, 8, maximum cycles to wait for each ALU_VLD beat before aborting; legal range 2..255.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VLD  in  1  upstream instruction valid.
- IN_RDY  out  1  block can accept an instruction.
- IN_OP  in  4  ALU opcode.
- IN_MOVI  in  2  operand-B select: 00 REG_B, 01 MEM, 10 IMM, 11 zero.
- IN_A, IN_B, IN_MEM, IN_IMM  in  32 each  operand values.
- IN_TAG  in  TAG_W  instruction tag.
- ALU_ACT  out  1  start request to the ALU.
- ALU_OP  out  4  opcode driven to the ALU.
- ALU_MOVI  out  2  operand-B select driven to the ALU.
- ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM  out  32 each  operands driven to the ALU.
- ALU_RDY  in  1  ALU idle.
- ALU_VLD  in  1  ALU result beat valid.
- ALU_DATA  in  32  ALU result beat.
- OUT_VLD  out  1  result valid.
- OUT_RDY  in  1  downstream accepts the result.
- OUT_DATA  out  64  result; normal ops are zero-extended, MUL is {hi, lo}.
- OUT_TAG  out  TAG_W  tag of the result.
- OUT_ERR  out  1  set on a result produced by timeout abort.
- PROTO_ERR  out  1  sticky flag: ALU_VLD seen while no beat was expected.

Behaviour:
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, OUT.
- Reset: state IDLE. Operand, tag, result and counter registers are cleared to 0. Resulting outputs: IN_RDY=1, ALU_ACT=0, OUT_VLD=0, OUT_ERR=0, PROTO_ERR=0, OUT_DATA=0. RST mid-operation abandons the instruction, and no output is produced for it.
- IDLE:
  - IN_RDY=1.
  - On IN_VLD the block captures op, movi, all operands, the tag, and is_mul = (IN_OP==4'b0010), then moves to ISSUE.
- ISSUE:
  - ALU_ACT = ALU_RDY, asserted for exactly one cycle.
  - When ALU_RDY=1 the block moves to WAIT_LO; otherwise it stays in ISSUE with ACT low.
- WAIT_LO:
  - When ALU_VLD=1, ALU_DATA is captured into result[31:0].
  - Next state: WAIT_HI if is_mul, else OUT.
- WAIT_HI:
  - When ALU_VLD=1, ALU_DATA is captured into result[63:32]; next state OUT.
- OUT:
  - OUT_VLD=1 until OUT_RDY.
  - On OUT_RDY the block moves to IDLE.
  - No new instruction is accepted in the same cycle (IN_RDY=0 in OUT).
- ALU operand/op/movi outputs are driven from the captured registers in every state, so they are stable from ISSUE through the last beat.
- Latency with ALU_RDY=1 and no stall:
  - IN handshake at cycle t; ACT at t+1; lo beat at t+2.
  - Normal op: OUT_VLD at t+3.
  - MUL: hi beat at t+3, OUT_VLD at t+4.
  - Throughput: one instruction per 4 cycles (5 for MUL), plus downstream stall.
- Timeout:
  - An 8-bit counter is cleared on entry to each WAIT state and increments each cycle without ALU_VLD.
  - When it reaches TIMEOUT-1 and ALU_VLD is still 0, the block moves to OUT with OUT_ERR=1 and OUT_DATA=0.
  - ALU_VLD in the same cycle as expiry wins: the beat is taken as normal.
- PROTO_ERR: set when ALU_VLD=1 in IDLE, ISSUE or OUT; cleared only by RST.
- MOVI=11 is passed through unchanged; the ALU selects zero.
- The block does not interpret any opcode except MUL detection.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode enum (ADD..DEC, 4-bit, ADD=0, SUB=1, MUL=2, ..., DEC=15);
  - the MOVI select enum (SRC_REG, SRC_MEM, SRC_IMM, SRC_ZERO);
  - constant OP_MUL;
  - the issue-state typedef.
- One natural sub-module: alu_beat_timer (load/clear, enable, expire output), reused for both WAIT states.

Test Plan:
- ADD: IN_A=5, IN_B=7, MOVI=00, tag=3, ALU model returns 12 at t+2 -> OUT_VLD at t+3, OUT_DATA=0x0000_0000_0000_000C, OUT_TAG=3, OUT_ERR=0, ACT high for exactly 1 cycle.
- MUL: A=0x1_0000, IMM=0x1_0000, MOVI=10, model returns beats 0x0 then 0x1 -> OUT_DATA=0x0000_0001_0000_0000 at t+4; ALU_IMM stays 0x1_0000 through both beats.
- ALU_RDY held low 3 cycles in ISSUE -> ACT stays 0 until ALU_RDY=1; latency grows by 3; operands unchanged.
- Model never asserts VLD, TIMEOUT=8 -> OUT_VLD 8 cycles after entering WAIT_LO with OUT_ERR=1, OUT_DATA=0; the next instruction completes normally.
- OUT_RDY low for 5 cycles with IN_VLD held high -> OUT_DATA/OUT_TAG stable, IN_RDY=0 throughout; the instruction is accepted the cycle after the OUT handshake (IDLE).
- RST asserted in WAIT_HI, then a spurious ALU_VLD while IDLE -> no OUT_VLD after reset, all outputs at reset values, PROTO_ERR=1 on the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU issue sequencer.
//   alu_op_e      - 4-bit ALU opcode. Only MUL matters to the sequencer.
//   alu_movi_e    - operand-B source select. It is passed through to the ALU.
//   OP_MUL        - opcode that returns two result beats.
//   issue_state_e - states of the issue sequencer.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_MUL = 4'd2,  ALU_AND = 4'd3,
    ALU_OR  = 4'd4,  ALU_XOR = 4'd5,  ALU_NOT = 4'd6,  ALU_SHL = 4'd7,
    ALU_SHR = 4'd8,  ALU_SAR = 4'd9,  ALU_ROL = 4'd10, ALU_ROR = 4'd11,
    ALU_CMP = 4'd12, ALU_MOV = 4'd13, ALU_INC = 4'd14, ALU_DEC = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_REG  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_IMM  = 2'b10,
    SRC_ZERO = 2'b11
  } alu_movi_e;

  localparam alu_op_e OP_MUL = ALU_MUL;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_OUT
  } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: bundles the three handshakes around the issue sequencer.
//   in_*     upstream instruction port (valid/ready) carrying the op, operands and tag
//   alu_*    ALU side: the ACT start pulse, the operands, the RDY idle flag, and the VLD/DATA beats
//   out_*    downstream result port (valid/ready) carrying the 64-bit data, the tag and the error flag
//   proto_err  sticky flag for unexpected ALU_VLD
// The master modport is the sequencer. The slave modport is its environment.
interface alu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in_vld;
  logic             in_rdy;
  logic [3:0]       in_op;
  logic [1:0]       in_movi;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      in_mem;
  logic [31:0]      in_imm;
  logic [TAG_W-1:0] in_tag;

  logic             alu_act;
  logic [3:0]       alu_op;
  logic [1:0]       alu_movi;
  logic [31:0]      alu_reg_a;
  logic [31:0]      alu_reg_b;
  logic [31:0]      alu_mem;
  logic [31:0]      alu_imm;
  logic             alu_rdy;
  logic             alu_vld;
  logic [31:0]      alu_data;

  logic             out_vld;
  logic             out_rdy;
  logic [63:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             proto_err;

  modport master (
    input  in_vld, in_op, in_movi, in_a, in_b, in_mem, in_imm, in_tag,
    output in_rdy,
    output alu_act, alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm,
    input  alu_rdy, alu_vld, alu_data,
    output out_vld, out_data, out_tag, out_err, proto_err,
    input  out_rdy
  );

  modport slave (
    output in_vld, in_op, in_movi, in_a, in_b, in_mem, in_imm, in_tag,
    input  in_rdy,
    input  alu_act, alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm,
    output alu_rdy, alu_vld, alu_data,
    input  out_vld, out_data, out_tag, out_err, proto_err,
    output out_rdy
  );
endinterface

// File: rtl/alu_beat_timer.sv
// alu_beat_timer: 8-bit beat-wait counter for the sequencer.
//   clk, rst  clock and synchronous active-high reset
//   clr       restart the count at 0 (takes priority over en)
//   en        count one waiting cycle
//   expire    count has reached TIMEOUT-1
// TIMEOUT must be in the range 2..255 so that TIMEOUT-1 fits in 8 bits.
module alu_beat_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = 8'd0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == 8'(TIMEOUT - 1));
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator-side sequencer for the ALU ACT/RDY/VLD handshake.
//   CLK, RST  clock and synchronous active-high reset
//   bus       alu_issue_ctrl_if master:
//             - takes one instruction from the upstream port
//             - issues it to the ALU
//             - collects one result beat, or two for MUL
//             - presents the 64-bit result and its tag downstream
//
// state      | meaning
// IDLE       | ready for an instruction, which is captured on in_vld
// ISSUE      | ACT follows ALU_RDY; leaves after the single ACT cycle
// WAIT_LO    | waiting for the low result beat (or timeout)
// WAIT_HI    | MUL only: waiting for the high result beat (or timeout)
// OUT        | result held valid until out_rdy
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 8
) (
  input logic              CLK,
  input logic              RST,
  alu_issue_ctrl_if.master bus
);
  issue_state_e     state_q, state_d;
  alu_op_e          op_q, op_d;
  alu_movi_e        movi_q, movi_d;
  logic [31:0]      a_q, a_d, b_q, b_d, mem_q, mem_d, imm_q, imm_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             is_mul_q, is_mul_d;
  logic [63:0]      result_q, result_d;
  logic             err_q, err_d;
  logic             proto_q, proto_d;
  logic             tmr_clr, tmr_en, tmr_expire;
  logic             in_rdy, alu_act, out_vld;

  alu_beat_timer #(.TIMEOUT(TIMEOUT)) u_beat_timer (
    .clk    (CLK),
    .rst    (RST),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    movi_d   = movi_q;
    a_d      = a_q;
    b_d      = b_q;
    mem_d    = mem_q;
    imm_d    = imm_q;
    tag_d    = tag_q;
    is_mul_d = is_mul_q;
    result_d = result_q;
    err_d    = err_q;
    proto_d  = proto_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    in_rdy   = 1'b0;
    alu_act  = 1'b0;
    out_vld  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_rdy = 1'b1;
        if (bus.alu_vld) proto_d = 1'b1;
        if (bus.in_vld) begin
          op_d     = alu_op_e'(bus.in_op);
          movi_d   = alu_movi_e'(bus.in_movi);
          a_d      = bus.in_a;
          b_d      = bus.in_b;
          mem_d    = bus.in_mem;
          imm_d    = bus.in_imm;
          tag_d    = bus.in_tag;
          is_mul_d = (bus.in_op == OP_MUL);
          result_d = 64'd0;
          err_d    = 1'b0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.alu_vld) proto_d = 1'b1;
        alu_act = bus.alu_rdy;
        if (bus.alu_rdy) begin
          tmr_clr = 1'b1;
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        // A beat arriving in the expiry cycle is still accepted.
        if (bus.alu_vld) begin
          result_d[31:0] = bus.alu_data;
          if (is_mul_q) begin
            tmr_clr = 1'b1;
            state_d = ST_WAIT_HI;
          end else begin
            state_d = ST_OUT;
          end
        end else if (tmr_expire) begin
          result_d = 64'd0;
          err_d    = 1'b1;
          state_d  = ST_OUT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (bus.alu_vld) begin
          result_d[63:32] = bus.alu_data;
          state_d         = ST_OUT;
        end else if (tmr_expire) begin
          result_d = 64'd0;
          err_d    = 1'b1;
          state_d  = ST_OUT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_OUT: begin
        out_vld = 1'b1;
        if (bus.alu_vld) proto_d = 1'b1;
        if (bus.out_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= ALU_ADD;
      movi_q   <= SRC_REG;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      mem_q    <= 32'd0;
      imm_q    <= 32'd0;
      tag_q    <= '0;
      is_mul_q <= 1'b0;
      result_q <= 64'd0;
      err_q    <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      movi_q   <= movi_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mem_q    <= mem_d;
      imm_q    <= imm_d;
      tag_q    <= tag_d;
      is_mul_q <= is_mul_d;
      result_q <= result_d;
      err_q    <= err_d;
      proto_q  <= proto_d;
    end
  end

  assign bus.in_rdy    = in_rdy;
  assign bus.alu_act   = alu_act;
  assign bus.alu_op    = op_q;
  assign bus.alu_movi  = movi_q;
  assign bus.alu_reg_a = a_q;
  assign bus.alu_reg_b = b_q;
  assign bus.alu_mem   = mem_q;
  assign bus.alu_imm   = imm_q;
  assign bus.out_vld   = out_vld;
  assign bus.out_data  = result_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_err   = err_q;
  assign bus.proto_err = proto_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // Observations from the most recent transaction
  int               g_lat, g_act_cnt, g_act_k;
  logic [63:0]      g_data;
  logic [TAG_W-1:0] g_tag;
  logic             g_err, g_ops_ok, g_out_ok, g_in_rdy0, g_done;

  // Behavioural ALU: operand-B select and a result per opcode
  function automatic logic [31:0] opb_of(input logic [1:0] movi, input logic [31:0] b,
                                         input logic [31:0] mem, input logic [31:0] imm);
    case (movi)
      2'b00:   return b;
      2'b01:   return mem;
      2'b10:   return imm;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] ob);
    logic [31:0] s;
    case (op)
      4'd0:    begin s = a + ob; return {32'd0, s}; end
      4'd1:    begin s = a - ob; return {32'd0, s}; end
      4'd2:    return 64'(a) * 64'(ob);
      default: begin s = a ^ ob; return {32'd0, s}; end
    endcase
  endfunction

  // Cycles from the input handshake to the first OUT_VLD. A delay of -1 means the beat never arrives.
  function automatic int exp_lat(input bit mul, input int rdy_low, input int lo_dly, input int hi_dly);
    int act_k, lo_k;
    act_k = 1 + rdy_low;
    if (lo_dly < 0) return act_k + 1 + TIMEOUT;
    lo_k = act_k + 1 + lo_dly;
    if (!mul) return lo_k + 1;
    if (hi_dly < 0) return lo_k + 1 + TIMEOUT;
    return lo_k + 2 + hi_dly;
  endfunction

  function automatic logic [63:0] exp_data(input logic [3:0] op, input logic [1:0] movi,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] mem, input logic [31:0] imm,
                                           input int lo_dly, input int hi_dly);
    if (lo_dly < 0 || (op == 4'd2 && hi_dly < 0)) return 64'd0;
    return alu_ref(op, a, opb_of(movi, b, mem, imm));
  endfunction

  // Drives one instruction through the upstream, ALU and downstream ports and records what happened.
  task automatic do_instr(input logic [3:0] op, input logic [1:0] movi,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] mem, input logic [31:0] imm,
                          input logic [TAG_W-1:0] tag, input int rdy_low,
                          input int lo_dly, input int hi_dly, input int stall, input bit hold);
    logic [63:0] r;
    int lo_at, hi_at, outs;
    bit mul;
    r = alu_ref(op, a, opb_of(movi, b, mem, imm));
    mul = (op == 4'd2);
    lo_at = -1; hi_at = -1; outs = 0;
    g_lat = -1; g_act_cnt = 0; g_act_k = -1; g_data = 64'd0; g_tag = '0; g_err = 1'b0;
    g_ops_ok = 1'b1; g_out_ok = 1'b1; g_in_rdy0 = 1'b0; g_done = 1'b0;
    for (int k = 0; k < 100 && !g_done; k++) begin
      @(posedge CLK); #1;
      if (k == 0) begin
        bus.in_op = op; bus.in_movi = movi; bus.in_a = a; bus.in_b = b;
        bus.in_mem = mem; bus.in_imm = imm; bus.in_tag = tag;
      end
      bus.in_vld   = (k == 0) || hold;
      bus.alu_rdy  = (k > rdy_low);
      bus.alu_vld  = (k == lo_at) || (k == hi_at);
      bus.alu_data = (k == hi_at) ? r[63:32] : r[31:0];
      bus.out_rdy  = (outs >= stall);
      @(negedge CLK);
      if (k == 0) g_in_rdy0 = bus.in_rdy;
      if (bus.alu_act) begin
        g_act_cnt++;
        if (g_act_k < 0) begin
          g_act_k = k;
          if (lo_dly >= 0) begin
            lo_at = k + 1 + lo_dly;
            if (mul && hi_dly >= 0) hi_at = lo_at + 1 + hi_dly;
          end
        end
      end
      if (k >= 1 && (bus.alu_op !== op || bus.alu_movi !== movi || bus.alu_reg_a !== a ||
                     bus.alu_reg_b !== b || bus.alu_mem !== mem || bus.alu_imm !== imm))
        g_ops_ok = 1'b0;
      if (bus.out_vld) begin
        if (outs == 0) begin
          g_lat = k; g_data = bus.out_data; g_tag = bus.out_tag; g_err = bus.out_err;
        end else if (bus.out_data !== g_data || bus.out_tag !== g_tag) begin
          g_out_ok = 1'b0;
        end
        if (bus.in_rdy !== 1'b0) g_out_ok = 1'b0;
        if (bus.out_rdy) g_done = 1'b1;
        outs++;
      end
    end
    bus.alu_vld = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", bus.in_rdy); end
    checks++; if (bus.alu_act !== 1'b0) begin errors++; $display("FAIL reset_alu_act: got %b want 0", bus.alu_act); end
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b want 0", bus.out_vld); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", bus.proto_err); end
    checks++; if (bus.out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
  endtask

  task automatic test_add();
    do_instr(4'd0, 2'b00, 32'd5, 32'd7, 32'hDEAD, 32'hBEEF, 4'd3, 0, 0, 0, 0, 1'b0);
    checks++; if (g_done !== 1'b1) begin errors++; $display("FAIL add_done: got %b want 1", g_done); end
    checks++; if (g_in_rdy0 !== 1'b1) begin errors++; $display("FAIL add_in_rdy: got %b want 1", g_in_rdy0); end
    checks++; if (g_lat != 3) begin errors++; $display("FAIL add_latency: got %0d want 3", g_lat); end
    checks++; if (g_data !== 64'h0000_0000_0000_000C) begin errors++; $display("FAIL add_data: got %h want c", g_data); end
    checks++; if (g_tag !== 4'd3) begin errors++; $display("FAIL add_tag: got %0d want 3", g_tag); end
    checks++; if (g_err !== 1'b0) begin errors++; $display("FAIL add_err: got %b want 0", g_err); end
    checks++; if (g_act_cnt != 1 || g_act_k != 1) begin errors++; $display("FAIL add_act: got %0d cycles at %0d want 1 at 1", g_act_cnt, g_act_k); end
  endtask

  task automatic test_mul();
    do_instr(4'd2, 2'b10, 32'h0001_0000, 32'h1234_5678, 32'h0, 32'h0001_0000, 4'd9, 0, 0, 0, 0, 1'b0);
    checks++; if (g_lat != 4) begin errors++; $display("FAIL mul_latency: got %0d want 4", g_lat); end
    checks++; if (g_data !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL mul_data: got %h want 0000000100000000", g_data); end
    checks++; if (g_tag !== 4'd9 || g_err !== 1'b0) begin errors++; $display("FAIL mul_tag_err: got %0d/%b want 9/0", g_tag, g_err); end
    checks++; if (g_ops_ok !== 1'b1) begin errors++; $display("FAIL mul_operands_stable: got %b want 1", g_ops_ok); end
  endtask

  task automatic test_rdy_stall();
    do_instr(4'd1, 2'b01, 32'd100, 32'd1, 32'd30, 32'd2, 4'd5, 3, 0, 0, 0, 1'b0);
    checks++; if (g_act_cnt != 1 || g_act_k != 4) begin errors++; $display("FAIL rdy_stall_act: got %0d cycles at %0d want 1 at 4", g_act_cnt, g_act_k); end
    checks++; if (g_lat != 6) begin errors++; $display("FAIL rdy_stall_latency: got %0d want 6", g_lat); end
    checks++; if (g_data !== 64'd70) begin errors++; $display("FAIL rdy_stall_data: got %h want 46", g_data); end
    checks++; if (g_ops_ok !== 1'b1) begin errors++; $display("FAIL rdy_stall_operands: got %b want 1", g_ops_ok); end
  endtask

  task automatic test_timeout();
    do_instr(4'd0, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0, 4'd7, 0, -1, 0, 0, 1'b0);
    checks++; if (g_lat != 2 + TIMEOUT) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", g_lat, 2 + TIMEOUT); end
    checks++; if (g_err !== 1'b1 || g_data !== 64'd0) begin errors++; $display("FAIL timeout_result: got err %b data %h want err 1 data 0", g_err, g_data); end
    do_instr(4'd0, 2'b10, 32'd10, 32'd0, 32'd0, 32'd20, 4'd8, 0, 0, 0, 0, 1'b0);
    checks++; if (g_lat != 3 || g_err !== 1'b0 || g_data !== 64'd30) begin errors++; $display("FAIL timeout_recover: got lat %0d err %b data %h want 3/0/1e", g_lat, g_err, g_data); end
    do_instr(4'd5, 2'b00, 32'hF0, 32'h0F, 32'd0, 32'd0, 4'd1, 0, TIMEOUT - 1, 0, 0, 1'b0);
    checks++; if (g_err !== 1'b0 || g_data !== 64'hFF || g_lat != 3 + TIMEOUT - 1) begin errors++; $display("FAIL timeout_edge_beat: got lat %0d err %b data %h want %0d/0/ff", g_lat, g_err, g_data, 3 + TIMEOUT - 1); end
    do_instr(4'd2, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0, 4'd2, 0, 0, -1, 0, 1'b0);
    checks++; if (g_lat != 3 + TIMEOUT || g_err !== 1'b1 || g_data !== 64'd0) begin errors++; $display("FAIL timeout_hi: got lat %0d err %b data %h want %0d/1/0", g_lat, g_err, g_data, 3 + TIMEOUT); end
  endtask

  task automatic test_back_to_back();
    do_instr(4'd0, 2'b00, 32'd40, 32'd2, 32'd0, 32'd0, 4'd12, 0, 0, 0, 5, 1'b1);
    checks++; if (g_lat != 3 || g_data !== 64'd42) begin errors++; $display("FAIL out_stall_result: got lat %0d data %h want 3/2a", g_lat, g_data); end
    checks++; if (g_out_ok !== 1'b1) begin errors++; $display("FAIL out_stall_hold: got %b want 1", g_out_ok); end
    do_instr(4'd1, 2'b11, 32'd9, 32'd5, 32'd6, 32'd7, 4'd13, 0, 0, 0, 0, 1'b0);
    checks++; if (g_in_rdy0 !== 1'b1 || g_act_k != 1) begin errors++; $display("FAIL back_to_back_accept: got in_rdy %b act at %0d want 1 at 1", g_in_rdy0, g_act_k); end
    checks++; if (g_data !== 64'd9 || g_tag !== 4'd13) begin errors++; $display("FAIL back_to_back_result: got %h tag %0d want 9 tag 13", g_data, g_tag); end
  endtask

  task automatic test_random();
    logic [3:0] op; logic [1:0] movi; logic [31:0] a, b, mem, imm; logic [TAG_W-1:0] tag;
    int rdy_low, lo_dly, hi_dly, stall, el;
    logic [63:0] ed;
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 2) == 0) ? 4'd2 : 4'($urandom_range(0, 15));
      movi = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom; mem = $urandom; imm = $urandom;
      tag = TAG_W'($urandom);
      rdy_low = $urandom_range(0, 3);
      lo_dly = $urandom_range(0, TIMEOUT); if (lo_dly == TIMEOUT) lo_dly = -1;
      hi_dly = $urandom_range(0, TIMEOUT); if (hi_dly == TIMEOUT) hi_dly = -1;
      stall = $urandom_range(0, 3);
      el = exp_lat(op == 4'd2, rdy_low, lo_dly, hi_dly);
      ed = exp_data(op, movi, a, b, mem, imm, lo_dly, hi_dly);
      do_instr(op, movi, a, b, mem, imm, tag, rdy_low, lo_dly, hi_dly, stall, 1'b0);
      checks++;
      if (!g_done || g_lat != el || g_data !== ed || g_tag !== tag ||
          g_err !== (ed == 64'd0 && (lo_dly < 0 || (op == 4'd2 && hi_dly < 0))) ||
          g_act_cnt != 1 || g_act_k != 1 + rdy_low || !g_ops_ok || !g_out_ok) begin
        errors++;
        $display("FAIL random_%0d: got lat %0d data %h tag %0d err %b act %0d@%0d ops %b out %b want lat %0d data %h tag %0d act 1@%0d",
                 i, g_lat, g_data, g_tag, g_err, g_act_cnt, g_act_k, g_ops_ok, g_out_ok, el, ed, tag, 1 + rdy_low);
      end
    end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL proto_clean: got %b want 0", bus.proto_err); end
  endtask

  task automatic test_reset_mid();
    bit seen_out;
    @(posedge CLK); #1;
    bus.in_vld = 1'b1; bus.in_op = 4'd2; bus.in_movi = 2'b10; bus.in_a = 32'd3; bus.in_imm = 32'd4;
    bus.in_tag = 4'd6; bus.alu_rdy = 1'b1; bus.alu_vld = 1'b0; bus.out_rdy = 1'b1;
    @(posedge CLK); #1; bus.in_vld = 1'b0;
    @(posedge CLK); #1; bus.alu_vld = 1'b1; bus.alu_data = 32'd12;
    @(posedge CLK); #1; bus.alu_vld = 1'b0; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.in_rdy !== 1'b1 || bus.alu_act !== 1'b0 || bus.out_vld !== 1'b0 || bus.out_err !== 1'b0 ||
        bus.proto_err !== 1'b0 || bus.out_data !== 64'd0 || bus.alu_reg_a !== 32'd0 || bus.alu_imm !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rdy %b act %b vld %b err %b proto %b data %h a %h imm %h want 1 0 0 0 0 0 0 0",
               bus.in_rdy, bus.alu_act, bus.out_vld, bus.out_err, bus.proto_err, bus.out_data, bus.alu_reg_a, bus.alu_imm);
    end
    @(posedge CLK); #1; bus.alu_vld = 1'b1;
    @(posedge CLK); #1; bus.alu_vld = 1'b0;
    @(negedge CLK);
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_set: got %b want 1", bus.proto_err); end
    seen_out = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (bus.out_vld) seen_out = 1'b1;
    end
    checks++; if (seen_out !== 1'b0) begin errors++; $display("FAIL mid_reset_no_output: got %b want 0", seen_out); end
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_sticky: got %b want 1", bus.proto_err); end
  endtask

  initial begin
    bus.in_vld = 1'b0; bus.in_op = 4'd0; bus.in_movi = 2'b00; bus.in_a = 32'd0; bus.in_b = 32'd0;
    bus.in_mem = 32'd0; bus.in_imm = 32'd0; bus.in_tag = '0;
    bus.alu_rdy = 1'b0; bus.alu_vld = 1'b0; bus.alu_data = 32'd0; bus.out_rdy = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_rdy_stall();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
